// File: rtl/lstm_y_out_buffer_if.sv
// Purpose: y_out sample strobe in, valid/ready 32-bit word stream out, for lstm_y_out_buffer.
// Latency: n/a (signal bundle only).
// Backpressure: m_ready throttles the word stream; the y_out side has no backpressure.
// Ports: y_out/y_out_valid (producer -> buffer), m_data/m_valid (buffer -> consumer),
//        m_ready (consumer -> buffer). slave = buffer view, master = producer/consumer view.
interface lstm_y_out_buffer_if;
    logic [15:0] y_out;
    logic        y_out_valid;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    modport slave (
        input  y_out,
        input  y_out_valid,
        input  m_ready,
        output m_data,
        output m_valid
    );

    modport master (
        output y_out,
        output y_out_valid,
        output m_ready,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/lstm_y_out_buffer.sv
// Purpose: FWFT FIFO capturing LSTM y_out samples and presenting them as 32-bit words.
// Latency: a sample pushed at edge N is on m_data with m_valid high right after edge N.
// Backpressure: m_ready stalls the head word; samples arriving while full (and not popping) are dropped and flag overflow.
// Ports: clk, rst (sync, active-high), bus (lstm_y_out_buffer_if.slave: y_out/y_out_valid in,
//        m_data/m_valid/m_ready out-stream), clear (sync flush), count, overflow (sticky), irq (count >= THRESHOLD).
// Optional build macro LSTM_YOUT_TIMESTAMP_EN: m_data[31:16] carries the 16-bit sample index captured
// with each sample instead of the sign extension of y_out.
module lstm_y_out_buffer #(
    parameter int DEPTH     = 64,
    parameter int THRESHOLD = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    lstm_y_out_buffer_if.slave       bus,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     irq
);
    localparam int AW        = $clog2(DEPTH);
    localparam int CNT_WIDTH = AW + 1;
`ifdef LSTM_YOUT_TIMESTAMP_EN
    localparam int MW = 32;
`else
    localparam int MW = 16;
`endif

    logic [MW-1:0]        mem [DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic [MW-1:0]        wr_word;
    logic [MW-1:0]        head;

`ifdef LSTM_YOUT_TIMESTAMP_EN
    logic [15:0] sample_idx;
    assign wr_word = {sample_idx, bus.y_out};
`else
    assign wr_word = bus.y_out;
`endif

    always_comb begin
        full = (count == CNT_WIDTH'(DEPTH));
        pop  = bus.m_valid && bus.m_ready && !clear;
        // A full FIFO still accepts a sample when the head leaves in the same cycle.
        push = bus.y_out_valid && !clear && (!full || pop);
        drop = bus.y_out_valid && !clear && full && !pop;

        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
`ifdef LSTM_YOUT_TIMESTAMP_EN
            sample_idx <= '0;
`endif
        end else begin
            count <= count_nxt;
            // Registered from next-state count so irq rises together with count.
            irq   <= (count_nxt >= CNT_WIDTH'(THRESHOLD));
            if (clear) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                overflow <= 1'b0;
`ifdef LSTM_YOUT_TIMESTAMP_EN
                sample_idx <= '0;
`endif
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (drop) overflow <= 1'b1;
`ifdef LSTM_YOUT_TIMESTAMP_EN
                // Counts dropped samples too, so gaps in the index expose losses.
                if (bus.y_out_valid) sample_idx <= sample_idx + 1'b1;
`endif
            end
        end
    end

    // Storage needs no reset: pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Head is read straight from storage (FWFT); gated to 0 while empty so reset shows m_data = 0.
    assign head        = mem[rd_ptr];
    assign bus.m_valid = (count != '0);
`ifdef LSTM_YOUT_TIMESTAMP_EN
    assign bus.m_data  = bus.m_valid ? head : 32'h0;
`else
    assign bus.m_data  = bus.m_valid ? {{16{head[15]}}, head} : 32'h0;
`endif
endmodule

// File: tb/tb_lstm_y_out_buffer.sv
// Purpose: self-checking bench for lstm_y_out_buffer against a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lstm_y_out_buffer;
    localparam int DEPTH     = 64;
    localparam int THRESHOLD = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [6:0] count;
    logic       overflow;
    logic       irq;

    lstm_y_out_buffer_if bus_if ();

    lstm_y_out_buffer #(.DEPTH(DEPTH), .THRESHOLD(THRESHOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .clear    (clear),
        .count    (count),
        .overflow (overflow),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents of the FIFO as expected output words.
    logic [31:0] ref_q[$];
    bit          ref_ovf = 1'b0;
    logic [15:0] ref_idx = 16'h0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [15:0] d, input logic [15:0] idx);
`ifdef LSTM_YOUT_TIMESTAMP_EN
        return {idx, d};
`else
        return {{16{d[15]}}, d};
`endif
    endfunction

    task automatic model_step(input logic v, input logic [15:0] d, input logic r, input logic clr);
        if (clr) begin
            ref_q.delete();
            ref_ovf = 1'b0;
            ref_idx = 16'h0;
        end else begin
            if (ref_q.size() != 0 && r) void'(ref_q.pop_front());
            if (v) begin
                if (ref_q.size() < DEPTH) ref_q.push_back(exp_word(d, ref_idx));
                else ref_ovf = 1'b1;
                ref_idx = ref_idx + 16'h1;
            end
        end
    endtask

    task automatic check_all();
        chk("m_valid", {31'b0, bus_if.m_valid}, {31'b0, ref_q.size() != 0});
        chk("count", {25'b0, count}, 32'(ref_q.size()));
        chk("overflow", {31'b0, overflow}, {31'b0, ref_ovf});
        chk("irq", {31'b0, irq}, {31'b0, ref_q.size() >= THRESHOLD});
        if (ref_q.size() != 0) chk("m_data", bus_if.m_data, ref_q[0]);
    endtask

    // One clock: drive inputs, advance model, sample #1 after the edge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic r,
                         input logic clr, input logic rs);
        bus_if.y_out_valid = v;
        bus_if.y_out       = d;
        bus_if.m_ready     = r;
        clear              = clr;
        rst                = rs;
        model_step(v, d, r, clr || rs);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [31:0] last_word;
    int          pr;

    initial begin
        bus_if.y_out_valid = 1'b0;
        bus_if.y_out       = 16'h0;
        bus_if.m_ready     = 1'b0;
        clear              = 1'b0;
        rst                = 1'b1;

        // Reset state
        cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("reset_m_data", bus_if.m_data, 32'h0);

        // Single sample with m_ready low, then drain
        cycle(1'b1, 16'h8001, 1'b0, 1'b0, 1'b0);
`ifdef LSTM_YOUT_TIMESTAMP_EN
        chk("single_data", bus_if.m_data, 32'h0000_8001);
`else
        chk("single_data", bus_if.m_data, 32'hFFFF_8001);
`endif
        chk("single_count", {25'b0, count}, 32'd1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("single_drained", {31'b0, bus_if.m_valid}, 32'd0);

        // Streaming 0..199 with m_ready held high
        do_reset();
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_cnt_le1", {31'b0, count <= 7'd1}, 32'd1);
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("stream_ovf", {31'b0, overflow}, 32'd0);

        // Overflow: 70 pushes into 64 entries, drain, then one more push
        do_reset();
        for (int i = 0; i < 70; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        chk("ovf_count", {25'b0, count}, 32'd64);
        chk("ovf_flag", {31'b0, overflow}, 32'd1);
        for (int i = 0; i < 64; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 16'h0BEE, 1'b0, 1'b0, 1'b0);
`ifdef LSTM_YOUT_TIMESTAMP_EN
        chk("ovf_next_idx", bus_if.m_data, {16'd70, 16'h0BEE});
`else
        chk("ovf_next_idx", bus_if.m_data, 32'h0000_0BEE);
`endif

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 64; i++) cycle(1'b1, 16'(i + 100), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
        chk("fullpp_count", {25'b0, count}, 32'd64);
        chk("fullpp_ovf", {31'b0, overflow}, 32'd0);
        last_word = 32'h0;
        for (int i = 0; i < 64; i++) begin
            if (count == 7'd1) last_word = bus_if.m_data;
            cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        end
        chk("fullpp_last", last_word, exp_word(16'h5A5A, 16'd64));

        // Threshold
        do_reset();
        for (int i = 0; i < 31; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        chk("thr_31", {31'b0, irq}, 32'd0);
        cycle(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
        chk("thr_32_irq", {31'b0, irq}, 32'd1);
        chk("thr_32_cnt", {25'b0, count}, 32'd32);
        cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("thr_pop", {31'b0, irq}, 32'd0);

        // Clear and reset precedence, each from 10 words with overflow set
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < 70; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 54; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            chk("prec_pre_cnt", {25'b0, count}, 32'd10);
            cycle(1'b1, 16'h1234, 1'b1, (k == 0), (k == 1));
            chk("prec_cnt", {25'b0, count}, 32'd0);
            chk("prec_vld", {31'b0, bus_if.m_valid}, 32'd0);
            chk("prec_ovf", {31'b0, overflow}, 32'd0);
            chk("prec_irq", {31'b0, irq}, 32'd0);
            if (k == 1) chk("prec_rst_data", bus_if.m_data, 32'h0);
            cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
            chk("prec_absent", {25'b0, count}, 32'd0);
        end

        // Randomized traffic with varying consumer speed, rare clear/reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) pr = int'($urandom_range(10, 90));
            cycle(($urandom_range(0, 99) < 60),
                  16'($urandom),
                  ($urandom_range(0, 99) < pr),
                  ($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 499) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lstm_y_out_buffer.md
Name: lstm_y_out_buffer

Overview:
- Downstream stage of the AXI4-Lite LSTM layer stack. Captures every 16-bit y_out sample qualified by y_out_valid into a first-word-fall-through FIFO.
- Presents samples to a valid/ready consumer as 32-bit words. The consumer is a DMA or the AXI read-back path.
- Reports occupancy, a sticky overflow flag and a level-threshold interrupt, so software can drain results without losing samples.

Parameters:
- DEPTH, 64, FIFO entries; must be a power of 2, minimum 4.
- THRESHOLD, 32, irq asserts when count >= THRESHOLD; range 1..DEPTH.
- CNT_WIDTH, $clog2(DEPTH)+1, width of count (localparam).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- y_out  input  16  signed sample from the LSTM layer stack
- y_out_valid  input  1  one-cycle strobe per sample; no backpressure upstream
- clear  input  1  synchronous flush of FIFO, flags and sample index
- m_data  output  32  head-of-FIFO word
- m_valid  output  1  m_data holds a valid word
- m_ready  input  1  consumer accepts the word when m_valid && m_ready
- count  output  CNT_WIDTH  number of stored words, 0..DEPTH
- overflow  output  1  sticky: a sample was dropped because the FIFO was full
- irq  output  1  registered, count >= THRESHOLD

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high.
- Reset: rd_ptr = 0, wr_ptr = 0, count = 0, m_valid = 0, overflow = 0, irq = 0, sample_idx = 0. m_data is don't-care while m_valid = 0; it drives 0 out of reset.
- Push: y_out_valid && !full writes the sample at wr_ptr. wr_ptr increments and wraps modulo DEPTH.
- Pop: m_valid && m_ready advances rd_ptr, with the same wrap.
- count:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged
- full = (count == DEPTH).
- Push while full: if the same cycle also pops, the push is accepted and count stays DEPTH. Otherwise the sample is dropped and overflow is set on the next edge. overflow holds until clear or rst.
- Latency: a sample pushed into an empty FIFO at edge N appears on m_data with m_valid = 1 after edge N. Zero added bubbles: back-to-back y_out_valid with m_ready held high streams one word per cycle.
- m_valid = (count != 0). m_data is always the entry at rd_ptr, whether mem is read combinationally or through a registered head register. When the entry at rd_ptr changes, m_data updates in the cycle after the pop.
- While m_valid && !m_ready, m_data is stable (AXI-stream rule).
- sample_idx: 16-bit, increments on every y_out_valid, including dropped samples. Wraps 0xFFFF -> 0x0000.
- Data format without the optional feature: m_data = {{16{y_out[15]}}, y_out}, i.e. sign-extended.
- irq is registered from the next-state count. It is high in the same cycle count first shows >= THRESHOLD.
- clear takes priority over push and pop in the same cycle. It empties the FIFO (pointers = 0, count = 0, m_valid = 0) and clears overflow, irq and sample_idx.
- A y_out_valid coincident with clear is discarded.
- rst mid-stream behaves like clear, plus m_data = 0.
- No state machine beyond the pointer and counter logic. The two states are implicit: EMPTY (count == 0) and NON_EMPTY.

Optional Feature:
- Macro: LSTM_YOUT_TIMESTAMP_EN.
- Defined: m_data[31:16] = sample_idx value captured with the sample; m_data[15:0] = y_out. This needs a 32-bit storage array. Gaps in the index reveal dropped samples.
- Undefined: 16-bit storage only, and m_data[31:16] is the sign extension of y_out[15]. sample_idx logic may be removed.
- All other behaviour is identical in both builds.

Test Plan:
- Single sample, from reset with m_ready = 0: y_out = 0x8001 pulsed once -> next cycle m_valid = 1, m_data = 0xFFFF8001 (feature off), count = 1. Raise m_ready -> one cycle later m_valid = 0, count = 0.
- Streaming: 200 consecutive samples 0..199 with m_ready held at 1 -> consumer receives 0..199 in order, count never exceeds 1, overflow = 0.
- Overflow: m_ready = 0, 70 samples pushed with DEPTH = 64 -> count = 64, overflow = 1. Drain yields samples 0..63. With LSTM_YOUT_TIMESTAMP_EN, upper halves read 0..63, and the next pushed sample carries index 70.
- Full with simultaneous push and pop: FIFO full, y_out_valid && m_ready in the same cycle -> count stays 64, overflow stays 0, the new sample is the last word drained.
- Threshold: push 31 samples -> irq = 0; push the 32nd -> irq = 1 in the same cycle count = 32; pop one -> irq = 0.
- Clear and reset precedence: FIFO holding 10 words with overflow = 1; assert clear together with y_out_valid and m_ready -> next cycle count = 0, m_valid = 0, overflow = 0, irq = 0, and the coincident sample is absent. Repeat with rst -> same result, m_data = 0.
